spu_fw_result_pipe: RTL

//  Parametrised result pipeline for an SPU execution unit. It carries {RegWr, RegTarget,

---
 rtl/spu_fw_result_pipe.sv | 107 ++++++++++
 1 files changed

// File: rtl/spu_fw_result_pipe.sv
// spu_fw_result_pipe
// Result pipeline for an SPU execution unit. Carries {wr, target, value, fwstage}
// through DEPTH registered stages to the register-file write port, with stall,
// per-stage flush and a multi-port combinational forwarding lookup.
module spu_fw_result_pipe #(
    parameter int DEPTH   = 7,
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 7,
    parameter int STAGE_W = 4,
    parameter int NUM_RD  = 3
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_stall,
    input  logic [DEPTH-1:0]           i_flush_mask,
    input  logic                       i_in_wr,
    input  logic [ADDR_W-1:0]          i_in_target,
    input  logic [DATA_W-1:0]          i_in_value,
    input  logic [STAGE_W-1:0]         i_in_fwstage,
    output logic                       o_wb_wr,
    output logic [ADDR_W-1:0]          o_wb_target,
    output logic [DATA_W-1:0]          o_wb_value,
    input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
    output logic [NUM_RD-1:0]          o_fw_hit,
    output logic [NUM_RD-1:0]          o_fw_pending,
    output logic [NUM_RD*DATA_W-1:0]   o_fw_value
);

    // Stage index width, and the common width used to compare a stage index
    // against an entry's fwstage (both zero-extended, unsigned).
    localparam int K_W   = $clog2(DEPTH + 1);
    localparam int CMP_W = (STAGE_W > K_W) ? STAGE_W : K_W;

    // Stage k lives at index k (1..DEPTH); stage DEPTH drives write-back.
    logic                      r_wr  [1:DEPTH];
    logic [ADDR_W-1:0]         r_tgt [1:DEPTH];
    logic signed [DATA_W-1:0]  r_val [1:DEPTH];
    logic [STAGE_W-1:0]        r_fws [1:DEPTH];

    logic [NUM_RD-1:0]         w_fw_hit;
    logic [NUM_RD-1:0]         w_fw_pending;
    logic [NUM_RD*DATA_W-1:0]  w_fw_value;

    // Stage registers: clear on reset, hold on stall (flush may still drop wr),
    // otherwise advance one stage. Flush bit i always refers to the entry that
    // currently sits in stage i (bit 0 = the input entry).
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_wr[k]  <= 1'b0;
                r_tgt[k] <= '0;
                r_val[k] <= '0;
                r_fws[k] <= '0;
            end
        end else if (i_stall) begin
            // The input is dropped; the upstream block re-presents it later.
            for (int k = 1; k < DEPTH; k++) begin
                if (i_flush_mask[k]) begin
                    r_wr[k] <= 1'b0;
                end
            end
        end else begin
            r_wr[1]  <= i_in_wr & ~i_flush_mask[0];
            r_tgt[1] <= i_in_target;
            r_val[1] <= i_in_value;
            r_fws[1] <= i_in_fwstage;
            for (int k = 2; k <= DEPTH; k++) begin
                r_wr[k]  <= r_wr[k-1] & ~i_flush_mask[k-1];
                r_tgt[k] <= r_tgt[k-1];
                r_val[k] <= r_val[k-1];
                r_fws[k] <= r_fws[k-1];
            end
        end
    end

    // Forwarding lookup per read port. Stages are visited oldest to youngest so
    // the youngest matching entry is the one that finally decides the result;
    // a pending young match therefore masks any older ready match.
    always_comb begin
        w_fw_hit     = '0;
        w_fw_pending = '0;
        w_fw_value   = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (r_wr[k] && (r_tgt[k] == i_rd_addr[r*ADDR_W +: ADDR_W])) begin
                    if (CMP_W'(k) >= CMP_W'(r_fws[k])) begin
                        w_fw_hit[r]                    = 1'b1;
                        w_fw_pending[r]                = 1'b0;
                        w_fw_value[r*DATA_W +: DATA_W] = r_val[k];
                    end else begin
                        w_fw_hit[r]                    = 1'b0;
                        w_fw_pending[r]                = 1'b1;
                        w_fw_value[r*DATA_W +: DATA_W] = '0;
                    end
                end
            end
        end
    end

    assign o_wb_wr      = r_wr[DEPTH];
    assign o_wb_target  = r_tgt[DEPTH];
    assign o_wb_value   = r_val[DEPTH];
    assign o_fw_hit     = w_fw_hit;
    assign o_fw_pending = w_fw_pending;
    assign o_fw_value   = w_fw_value;

endmodule
